// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around the 4:1 dataflow mux: steps the selects through channels
// 0..3 with a fixed dwell, captures Q per channel and publishes a 4-bit frame snapshot.
//
// state | meaning
// IDLE  | selects parked at channel 0, waiting for start
// SCAN  | dwelling on channel ch, capturing q_in when the dwell counter hits zero
module mux_scan_ctrl #(
    parameter int DWELL  = 4,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic              q_in,
    output logic              sel_a,
    output logic              sel_b,
    output logic [3:0]        sample,
    output logic              sample_valid,
    output logic              done,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    state_t              state_q, state_d;
    logic [1:0]          ch_q, ch_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [2:0]          shadow_q, shadow_d;
    logic [3:0]          sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ch_q           <= 2'd0;
            cnt_q          <= 8'd0;
            shadow_q       <= 3'd0;
            sample_q       <= 4'd0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        cnt_d          = cnt_q;
        shadow_d       = shadow_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        done_d         = 1'b0;
        frame_cnt_d    = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SCAN;
                    ch_d    = 2'd0;
                    cnt_d   = DWELL_M1;
                end
            end
            SCAN: begin
                // abort wins even over a frame-end edge; partial shadow bits are kept
                if (abort) begin
                    state_d = IDLE;
                    ch_d    = 2'd0;
                    cnt_d   = 8'd0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (ch_q != 2'd3) begin
                    case (ch_q)
                        2'd0:    shadow_d[0] = q_in;
                        2'd1:    shadow_d[1] = q_in;
                        default: shadow_d[2] = q_in;
                    endcase
                    ch_d  = ch_q + 2'd1;
                    cnt_d = DWELL_M1;
                end else begin
                    sample_d       = {q_in, shadow_q};
                    sample_valid_d = 1'b1;
                    frame_cnt_d    = frame_cnt_q + FCNT_W'(1);
                    ch_d           = 2'd0;
                    if (continuous) begin
                        cnt_d = DWELL_M1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = 2'd0;
                cnt_d   = 8'd0;
            end
        endcase

        busy_d = (state_d == SCAN);
    end

    assign sel_a        = ch_q[0];
    assign sel_b        = ch_q[1];
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a DWELL=4 instance for frame timing/abort/reset cases and a
// DWELL=1 instance for back-to-back frames and counter wrap; frames are scoreboarded.
module tb_mux_scan_ctrl;

    typedef struct {
        logic [3:0] smp;
        logic       dn;
        logic [7:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start4, cont4, abort4, q4, sel_a4, sel_b4, valid4, done4, busy4;
    logic [3:0] sample4, pat4;
    logic [7:0] fcnt4;

    logic       start1, cont1, abort1, q1, sel_a1, sel_b1, valid1, done1, busy1;
    logic [3:0] sample1, pat1;
    logic [7:0] fcnt1;

    assign q4 = pat4[{sel_b4, sel_a4}];
    assign q1 = pat1[{sel_b1, sel_a1}];

    mux_scan_ctrl #(.DWELL(4), .FCNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .continuous(cont4), .abort(abort4),
        .q_in(q4), .sel_a(sel_a4), .sel_b(sel_b4), .sample(sample4),
        .sample_valid(valid4), .done(done4), .busy(busy4), .frame_cnt(fcnt4)
    );

    mux_scan_ctrl #(.DWELL(1), .FCNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .continuous(cont1), .abort(abort1),
        .q_in(q1), .sel_a(sel_a1), .sel_b(sel_b1), .sample(sample1),
        .sample_valid(valid1), .done(done1), .busy(busy1), .frame_cnt(fcnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp4[$];
    exp_t exp1[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push4(input logic [3:0] s, input logic d, input logic [7:0] f);
        exp_t e;
        e.smp = s; e.dn = d; e.fc = f;
        exp4.push_back(e);
    endtask

    task automatic push1(input logic [3:0] s, input logic d, input logic [7:0] f);
        exp_t e;
        e.smp = s; e.dn = d; e.fc = f;
        exp1.push_back(e);
    endtask

    task automatic pulse_start4();
        start4 = 1'b1;
        step(1);
        start4 = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid4) begin
            if (exp4.size() == 0) begin
                chk("sb4_unexpected_valid", 32'(valid4), 32'd0);
            end else begin
                e = exp4.pop_front();
                chk("sb4_sample", 32'(sample4), 32'(e.smp));
                chk("sb4_done", 32'(done4), 32'(e.dn));
                chk("sb4_fcnt", 32'(fcnt4), 32'(e.fc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid1) begin
            if (exp1.size() == 0) begin
                chk("sb1_unexpected_valid", 32'(valid1), 32'd0);
            end else begin
                e = exp1.pop_front();
                chk("sb1_sample", 32'(sample1), 32'(e.smp));
                chk("sb1_done", 32'(done1), 32'(e.dn));
                chk("sb1_fcnt", 32'(fcnt1), 32'(e.fc));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start4 = 1'b0; cont4 = 1'b0; abort4 = 1'b0; pat4 = 4'd0;
        start1 = 1'b0; cont1 = 1'b0; abort1 = 1'b0; pat1 = 4'd0;
        #12;
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_sel", 32'({sel_b4, sel_a4}), 32'd0);
        chk("rst_sample", 32'(sample4), 32'd0);
        chk("rst_valid", 32'(valid4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_fcnt", 32'(fcnt4), 32'd0);
        rst_n = 1'b1;
        step(2);

        // single-shot frame, A..D = 1,0,1,1
        pat4 = 4'b1101;
        push4(4'b1101, 1'b1, 8'd1);
        pulse_start4();
        for (int i = 0; i < 16; i++) begin
            chk("t1_sel", 32'({sel_b4, sel_a4}), 32'(i / 4));
            chk("t1_busy", 32'(busy4), 32'd1);
            chk("t1_novalid", 32'(valid4), 32'd0);
            step(1);
        end
        chk("t1_valid", 32'(valid4), 32'd1);
        chk("t1_done", 32'(done4), 32'd1);
        chk("t1_busy_fall", 32'(busy4), 32'd0);
        chk("t1_sample", 32'(sample4), 32'b1101);
        chk("t1_fcnt", 32'(fcnt4), 32'd1);
        step(1);
        chk("t1_valid_pulse", 32'(valid4), 32'd0);
        chk("t1_done_pulse", 32'(done4), 32'd0);
        step(3);

        // continuous frames, A..D = 0,1,1,0; continuous dropped mid third frame
        pat4 = 4'b0110;
        cont4 = 1'b1;
        push4(4'b0110, 1'b0, 8'd2);
        pulse_start4();
        step(15);
        chk("t2_valid_early", 32'(valid4), 32'd0);
        step(1);
        chk("t2_valid_e16", 32'(valid4), 32'd1);
        chk("t2_sel_nogap", 32'({sel_b4, sel_a4}), 32'd0);
        chk("t2_busy_e16", 32'(busy4), 32'd1);
        chk("t2_nodone_e16", 32'(done4), 32'd0);
        push4(4'b0110, 1'b0, 8'd3);
        step(16);
        chk("t2_valid_e32", 32'(valid4), 32'd1);
        chk("t2_sel_e32", 32'({sel_b4, sel_a4}), 32'd0);
        step(8);
        cont4 = 1'b0;
        push4(4'b0110, 1'b1, 8'd4);
        step(7);
        chk("t2_busy_e47", 32'(busy4), 32'd1);
        step(1);
        chk("t2_done_e48", 32'(done4), 32'd1);
        chk("t2_busy_e48", 32'(busy4), 32'd0);
        chk("t2_fcnt_e48", 32'(fcnt4), 32'd4);
        step(1);
        chk("t2_idle", 32'(busy4), 32'd0);
        step(2);

        // abort on channel 2, then a clean frame
        pat4 = 4'b0011;
        pulse_start4();
        step(9);
        chk("t3_sel_ch2", 32'({sel_b4, sel_a4}), 32'd2);
        abort4 = 1'b1;
        step(1);
        abort4 = 1'b0;
        chk("t3_busy", 32'(busy4), 32'd0);
        chk("t3_sel", 32'({sel_b4, sel_a4}), 32'd0);
        chk("t3_sample_kept", 32'(sample4), 32'b0110);
        chk("t3_fcnt_kept", 32'(fcnt4), 32'd4);
        chk("t3_novalid", 32'(valid4), 32'd0);
        chk("t3_nodone", 32'(done4), 32'd0);
        step(20);
        chk("t3_stays_idle", 32'(busy4), 32'd0);
        pat4 = 4'b1010;
        push4(4'b1010, 1'b1, 8'd5);
        pulse_start4();
        step(16);
        chk("t3_new_valid", 32'(valid4), 32'd1);
        chk("t3_new_sample", 32'(sample4), 32'b1010);
        step(2);

        // start re-pulsed while busy
        pat4 = 4'b0101;
        push4(4'b0101, 1'b1, 8'd6);
        pulse_start4();
        step(3);
        start4 = 1'b1;
        step(1);
        start4 = 1'b0;
        step(6);
        start4 = 1'b1;
        step(1);
        start4 = 1'b0;
        step(4);
        chk("t4_novalid_e15", 32'(valid4), 32'd0);
        chk("t4_busy_e15", 32'(busy4), 32'd1);
        step(1);
        chk("t4_valid_e16", 32'(valid4), 32'd1);
        chk("t4_done_e16", 32'(done4), 32'd1);
        step(1);
        chk("t4_idle_after", 32'(busy4), 32'd0);
        step(4);

        // asynchronous reset mid-frame
        pat4 = 4'b1111;
        pulse_start4();
        step(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy4), 32'd0);
        chk("t5_sel", 32'({sel_b4, sel_a4}), 32'd0);
        chk("t5_sample", 32'(sample4), 32'd0);
        chk("t5_fcnt", 32'(fcnt4), 32'd0);
        chk("t5_valid", 32'(valid4), 32'd0);
        chk("t5_done", 32'(done4), 32'd0);
        #3;
        rst_n = 1'b1;
        step(10);
        chk("t5_idle", 32'(busy4), 32'd0);
        pat4 = 4'b1001;
        push4(4'b1001, 1'b1, 8'd1);
        pulse_start4();
        step(16);
        chk("t5_frame_valid", 32'(valid4), 32'd1);
        chk("t5_frame_fcnt", 32'(fcnt4), 32'd1);
        step(2);

        // DWELL=1 continuous: 256 frames, counter wrap, abort on a frame-end edge
        cont1 = 1'b1;
        start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        for (int f = 1; f <= 256; f++) begin
            pat1 = 4'($urandom_range(0, 15));
            push1(pat1, 1'b0, 8'(f % 256));
            step(3);
            chk("t6_novalid", 32'(valid1), 32'd0);
            step(1);
            chk("t6_valid", 32'(valid1), 32'd1);
        end
        chk("t6_wrap", 32'(fcnt1), 32'd0);
        step(3);
        abort1 = 1'b1;
        step(1);
        abort1 = 1'b0;
        chk("t6_abort_novalid", 32'(valid1), 32'd0);
        chk("t6_abort_busy", 32'(busy1), 32'd0);
        chk("t6_abort_nodone", 32'(done1), 32'd0);
        chk("t6_abort_fcnt", 32'(fcnt1), 32'd0);
        step(4);

        chk("sb4_drained", 32'(exp4.size()), 32'd0);
        chk("sb1_drained", 32'(exp1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
